// File: rtl/fir_stim_source.sv
`default_nettype none
// ============================================================================
// Module      : fir_stim_source
// Description : Q8.8 test-waveform source (impulse/step/alternating/ramp/zero)
//               with valid/ready handshake and programmable inter-sample gap.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stim_source #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] amplitude,
    input  logic [LEN_W-1:0]  length,
    input  logic [GAP_W-1:0]  gap,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  sample_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);
    localparam logic [GAP_W-1:0]  c_gap_one = GAP_W'(1);
    localparam logic [DATA_W-1:0] c_pos_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] c_neg_min = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_mode;
    logic [DATA_W-1:0]   r_amp;
    logic [LEN_W-1:0]    r_len;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_k;
    logic [DATA_W:0]     r_acc;

    logic                w_hs;
    logic                w_last;
    logic [DATA_W:0]     w_amp_x;
    logic [DATA_W:0]     w_neg;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_neg_sat;
    logic [DATA_W-1:0]   w_sum_sat;
    logic [DATA_W-1:0]   w_sample;

    // Clamp a one-bit-wider result back into DATA_W on overflow.
    function automatic logic [DATA_W-1:0] f_sat(input logic [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? c_neg_min : c_pos_max;
        return v[DATA_W-1:0];
    endfunction

    assign w_hs      = (r_state == S_SEND) && out_ready;
    assign w_last    = (r_k == (r_len - c_len_one));
    assign w_amp_x   = {r_amp[DATA_W-1], r_amp};
    assign w_neg     = (~w_amp_x) + {{DATA_W{1'b0}}, 1'b1};
    assign w_sum     = r_acc + w_amp_x;
    assign w_neg_sat = f_sat(w_neg);
    assign w_sum_sat = f_sat(w_sum);

    always_comb begin
        w_sample = '0;
        case (r_mode)
            3'd0:    w_sample = (r_k == '0) ? r_amp : '0;
            3'd1:    w_sample = r_amp;
            3'd2:    w_sample = r_k[0] ? w_neg_sat : r_amp;
            3'd3:    w_sample = r_acc[DATA_W-1:0];
            default: w_sample = '0;
        endcase
    end

    assign out_valid  = (r_state == S_SEND);
    assign out_data   = out_valid ? w_sample : '0;
    assign sample_idx = r_k;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = (length == '0) ? S_DONE : S_SEND;
                S_SEND: begin
                    if (out_ready) begin
                        if (w_last)            w_next = S_DONE;
                        else if (r_gap != '0)  w_next = S_GAP;
                        else                   w_next = S_SEND;
                    end
                end
                S_GAP:  if (r_cnt == c_gap_one) w_next = S_SEND;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Configuration, sample index, gap counter and ramp accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= '0;
            r_amp  <= '0;
            r_len  <= '0;
            r_gap  <= '0;
            r_cnt  <= '0;
            r_k    <= '0;
            r_acc  <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_amp  <= amplitude;
                        r_len  <= length;
                        r_gap  <= gap;
                        r_k    <= '0;
                        r_acc  <= '0;
                    end
                end
                S_SEND: begin
                    if (w_hs && !w_last) begin
                        r_k   <= r_k + c_len_one;
                        r_acc <= {w_sum_sat[DATA_W-1], w_sum_sat};
                        r_cnt <= r_gap;
                    end
                end
                S_GAP:   r_cnt <= r_cnt - c_gap_one;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
